// File: rtl/i2c_master_core.sv
// Single-master I2C register-access controller: 8-bit register writes and reads
// against 7-bit-addressed slaves, open-drain SCL/SDA with clock-stretch support.
module i2c_master_core #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int I2C_FREQ = 100_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr,
  input  logic       i_rd,
  input  logic [6:0] i_slave_addr,
  input  logic [7:0] i_reg_addr,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_rdata,
  output logic       o_busy,
  output logic       o_rdata_valid,
  output logic       o_nack_slave,
  output logic       o_nack_addr,
  output logic       o_nack_data,
  inout  wire        SCL,
  inout  wire        SDA
);
  localparam int Q  = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QW = (Q > 1) ? $clog2(Q) : 1;

  typedef enum logic [2:0] {
    IDLE, START, SEND_BYTE, GET_ACK, RESTART, READ_BYTE, SEND_NACK, STOP
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [2:0]    phase_q, phase_d, bit_q, bit_d;
  logic [1:0]    frame_q, frame_d;
  logic [7:0]    shreg_q, shreg_d, rdata_q, rdata_d, reg_q, reg_d, wdata_q, wdata_d;
  logic [6:0]    addr_q, addr_d;
  logic          scl_oe_q, scl_oe_d, sda_oe_q, sda_oe_d;
  logic          rd_q, rd_d, ack_q, ack_d, valid_q, valid_d;
  logic          nslv_q, nslv_d, nreg_q, nreg_d, ndat_q, ndat_d;
  logic          scl_in, sda_in, stretch, qtick;

  assign SCL    = scl_oe_q ? 1'b0 : 1'bz;
  assign SDA    = sda_oe_q ? 1'b0 : 1'bz;
  assign scl_in = SCL;
  assign sda_in = SDA;

  // A released SCL still read low means a slave is stretching: freeze the quarter timer.
  assign stretch = !scl_oe_q && !scl_in;
  assign qtick   = (qcnt_q == QW'(Q - 1)) && !stretch;

  assign o_rdata       = rdata_q;
  assign o_busy        = (state_q != IDLE);
  assign o_rdata_valid = valid_q;
  assign o_nack_slave  = nslv_q;
  assign o_nack_addr   = nreg_q;
  assign o_nack_data   = ndat_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      qcnt_q   <= '0;
      phase_q  <= '0;
      bit_q    <= '0;
      frame_q  <= '0;
      shreg_q  <= '0;
      rdata_q  <= '0;
      reg_q    <= '0;
      wdata_q  <= '0;
      addr_q   <= '0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      rd_q     <= 1'b0;
      ack_q    <= 1'b0;
      valid_q  <= 1'b0;
      nslv_q   <= 1'b0;
      nreg_q   <= 1'b0;
      ndat_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      shreg_q  <= shreg_d;
      rdata_q  <= rdata_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      scl_oe_q <= scl_oe_d;
      sda_oe_q <= sda_oe_d;
      rd_q     <= rd_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      nslv_q   <= nslv_d;
      nreg_q   <= nreg_d;
      ndat_q   <= ndat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    phase_d  = phase_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    shreg_d  = shreg_q;
    rdata_d  = rdata_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    scl_oe_d = scl_oe_q;
    sda_oe_d = sda_oe_q;
    rd_d     = rd_q;
    ack_d    = ack_q;
    valid_d  = 1'b0;
    nslv_d   = nslv_q;
    nreg_d   = nreg_q;
    ndat_d   = ndat_q;

    if (state_q != IDLE && !stretch) qcnt_d = qtick ? '0 : qcnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        qcnt_d  = '0;
        phase_d = '0;
        bit_d   = '0;
        if (i_wr || i_rd) begin
          state_d  = START;
          rd_d     = !i_wr;
          addr_d   = i_slave_addr;
          reg_d    = i_reg_addr;
          wdata_d  = i_wdata;
          shreg_d  = {i_slave_addr, 1'b0};
          frame_d  = 2'd0;
          sda_oe_d = 1'b1;
          nslv_d   = 1'b0;
          nreg_d   = 1'b0;
          ndat_d   = 1'b0;
        end
      end
      START: if (qtick) begin
        phase_d = phase_q + 3'd1;
        if (phase_q == 3'd1) scl_oe_d = 1'b1;
        if (phase_q == 3'd2) begin
          state_d = SEND_BYTE;
          phase_d = '0;
        end
      end
      SEND_BYTE, GET_ACK, READ_BYTE, SEND_NACK: if (qtick) begin
        phase_d = phase_q + 3'd1;
        case (phase_q)
          3'd0: sda_oe_d = (state_q == SEND_BYTE) ? ~shreg_q[7] : 1'b0;
          3'd1: scl_oe_d = 1'b0;
          3'd2: begin
            if (state_q == READ_BYTE) shreg_d = {shreg_q[6:0], sda_in};
            if (state_q == GET_ACK)   ack_d   = sda_in;
          end
          default: begin
            scl_oe_d = 1'b1;
            phase_d  = '0;
            case (state_q)
              SEND_BYTE: begin
                shreg_d = {shreg_q[6:0], 1'b0};
                bit_d   = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = GET_ACK;
              end
              READ_BYTE: begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = SEND_NACK;
              end
              SEND_NACK: begin
                state_d  = STOP;
                sda_oe_d = 1'b1;
                rdata_d  = shreg_q;
                valid_d  = 1'b1;
              end
              default: begin
                // End of ACK slot: abort to STOP on NACK, else pick the next frame.
                if (ack_q) begin
                  state_d  = STOP;
                  sda_oe_d = 1'b1;
                  case (frame_q)
                    2'd1:    nreg_d = 1'b1;
                    2'd2:    ndat_d = 1'b1;
                    default: nslv_d = 1'b1;
                  endcase
                end else begin
                  case (frame_q)
                    2'd0: begin
                      state_d = SEND_BYTE;
                      frame_d = 2'd1;
                      shreg_d = reg_q;
                    end
                    2'd1: begin
                      if (rd_q) state_d = RESTART;
                      else begin
                        state_d = SEND_BYTE;
                        frame_d = 2'd2;
                        shreg_d = wdata_q;
                      end
                    end
                    2'd2: begin
                      state_d  = STOP;
                      sda_oe_d = 1'b1;
                    end
                    default: state_d = READ_BYTE;
                  endcase
                end
              end
            endcase
          end
        endcase
      end
      RESTART: if (qtick) begin
        phase_d = phase_q + 3'd1;
        case (phase_q)
          3'd0: scl_oe_d = 1'b0;
          3'd2: sda_oe_d = 1'b1;
          3'd4: scl_oe_d = 1'b1;
          3'd5: begin
            state_d = SEND_BYTE;
            phase_d = '0;
            frame_d = 2'd3;
            shreg_d = {addr_q, 1'b1};
          end
          default: ;
        endcase
      end
      STOP: if (qtick) begin
        phase_d = phase_q + 3'd1;
        case (phase_q)
          3'd0: scl_oe_d = 1'b0;
          3'd2: sda_oe_d = 1'b0;
          3'd4: begin
            state_d = IDLE;
            phase_d = '0;
          end
          default: ;
        endcase
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_i2c_master_core.sv
// Directed bench for i2c_master_core: behavioural I2C slave on pulled-up wires,
// hand-computed bytes, flags and transaction lengths (Q = 10 clocks).
module tb_i2c_master_core;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_wr = 1'b0, i_rd = 1'b0;
  logic [6:0] i_slave_addr = '0;
  logic [7:0] i_reg_addr = '0, i_wdata = '0;
  logic [7:0] o_rdata;
  logic       o_busy, o_rdata_valid, o_nack_slave, o_nack_addr, o_nack_data;
  wire        scl, sda;

  pullup (scl);
  pullup (sda);

  i2c_master_core #(.CLK_FREQ(4_000_000), .I2C_FREQ(100_000)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr(i_wr), .i_rd(i_rd),
    .i_slave_addr(i_slave_addr), .i_reg_addr(i_reg_addr), .i_wdata(i_wdata),
    .o_rdata(o_rdata), .o_busy(o_busy), .o_rdata_valid(o_rdata_valid),
    .o_nack_slave(o_nack_slave), .o_nack_addr(o_nack_addr), .o_nack_data(o_nack_data),
    .SCL(scl), .SDA(sda)
  );

  always #5 clk = ~clk;

  // Slave controls (written by stimulus only).
  bit         present = 1'b1;
  int         nack_at = 0;
  logic [7:0] slv_rdata = 8'h5C;
  bit         stretch_req = 1'b0;

  // Slave state and log (written by the slave process only).
  logic       sda_drv = 1'b0;
  int         hold = 0;
  int         bitcnt = 0, starts = 0, stops = 0;
  bit         in_frame = 0, in_txn = 0, tx_mode = 0, addr_phase = 0, acked = 0;
  bit         stretched = 0, m_ack_bit = 0;
  logic [7:0] sh = '0, tx_sh = '0;
  logic [7:0] rx_q[$];

  assign scl = (hold != 0) ? 1'b0 : 1'bz;
  assign sda = sda_drv ? 1'b0 : 1'bz;

  int vcnt = 0;
  always @(negedge clk) if (o_rdata_valid) vcnt <= vcnt + 1;

  initial begin : slave
    bit ps, pd, cs, cd;
    ps = 1'b1; pd = 1'b1;
    forever begin
      @(negedge clk);
      cs = scl; cd = sda;
      if (rst) begin
        in_frame = 0; in_txn = 0; sda_drv = 1'b0; hold = 0;
      end else begin
        if (hold > 0) hold--;
        if (ps && cs && pd && !cd) begin
          if (!in_txn) begin
            rx_q.delete(); starts = 0; stops = 0; stretched = 0;
          end
          in_txn = 1; in_frame = 1; bitcnt = 0; tx_mode = 0; addr_phase = 1;
          sda_drv = 1'b0; starts++;
        end else if (ps && cs && !pd && cd) begin
          in_txn = 0; in_frame = 0; sda_drv = 1'b0; stops++;
        end else if (in_frame && !ps && cs) begin
          if (bitcnt < 8) begin
            if (!tx_mode) sh = {sh[6:0], cd};
            bitcnt++;
          end else begin
            if (tx_mode) m_ack_bit = cd;
            bitcnt = 9;
          end
        end else if (in_frame && ps && !cs) begin
          if (bitcnt == 8) begin
            if (!tx_mode) begin
              rx_q.push_back(sh);
              if (addr_phase) acked = present && (sh[7:1] == 7'h42);
              else            acked = (rx_q.size() != nack_at);
              sda_drv = acked;
            end else sda_drv = 1'b0;
          end else if (bitcnt == 9) begin
            bitcnt = 0; sda_drv = 1'b0;
            if (tx_mode || !acked) in_frame = 0;
            else if (addr_phase && sh[0]) begin
              tx_mode = 1; tx_sh = slv_rdata; sda_drv = !tx_sh[7];
            end
            addr_phase = 0;
          end else if (tx_mode && bitcnt > 0) begin
            tx_sh = {tx_sh[6:0], 1'b0}; sda_drv = !tx_sh[7];
          end
          if (stretch_req && !stretched && !tx_mode && rx_q.size() == 1 && bitcnt == 3) begin
            hold = 1000; stretched = 1;
          end
        end
      end
      ps = cs; pd = cd;
    end
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input bit wr, input logic [7:0] r, input logic [7:0] d,
                        input int poke, output int cyc);
    @(negedge clk);
    i_wr = wr; i_rd = !wr; i_slave_addr = 7'h42; i_reg_addr = r; i_wdata = d;
    @(negedge clk);
    i_wr = 1'b0; i_rd = 1'b0;
    cyc = 0;
    while (o_busy && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (poke != 0 && cyc == poke) begin
        i_wr = 1'b1; i_wdata = 8'h33; i_slave_addr = 7'h11;
      end else i_wr = 1'b0;
    end
    chk("busy_done", o_busy, 1'b0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    int cyc, v0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_scl", scl, 1'b1);
    chk("rst_sda", sda, 1'b1);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_flags", {o_nack_slave, o_nack_addr, o_nack_data}, 3'b000);
    chk("rst_rdata", o_rdata, 8'h00);
    chk("rst_valid", o_rdata_valid, 1'b0);

    // Write 0x80 -> reg 0x12 @ 0x42: 3+108+5 quarters.
    do_cmd(1'b1, 8'h12, 8'h80, 0, cyc);
    chk("wr_len", cyc, 1160);
    chk("wr_nbytes", rx_q.size(), 3);
    chk("wr_b0", rx_q[0], 8'h84);
    chk("wr_b1", rx_q[1], 8'h12);
    chk("wr_b2", rx_q[2], 8'h80);
    chk("wr_starts", starts, 1);
    chk("wr_stops", stops, 1);
    chk("wr_flags", {o_nack_slave, o_nack_addr, o_nack_data}, 3'b000);
    chk("wr_bus", {scl, sda}, 2'b11);

    // Read reg 0x0A: 3 + 18*4 + 6 + 9*4 + 8*4 + 4 + 5 quarters.
    v0 = vcnt;
    do_cmd(1'b0, 8'h0A, 8'h00, 0, cyc);
    chk("rd_len", cyc, 1580);
    chk("rd_b0", rx_q[0], 8'h84);
    chk("rd_b1", rx_q[1], 8'h0A);
    chk("rd_b2", rx_q[2], 8'h85);
    chk("rd_starts", starts, 2);
    chk("rd_stops", stops, 1);
    chk("rd_data", o_rdata, 8'h5C);
    chk("rd_valid_cnt", vcnt - v0, 1);
    chk("rd_master_nack", m_ack_bit, 1'b1);
    chk("rd_flags", {o_nack_slave, o_nack_addr, o_nack_data}, 3'b000);

    slv_rdata = 8'hA3;
    do_cmd(1'b0, 8'h3C, 8'h00, 0, cyc);
    chk("rd2_data", o_rdata, 8'hA3);
    chk("rd2_b1", rx_q[1], 8'h3C);

    // Absent slave: START + one frame + STOP.
    present = 1'b0;
    do_cmd(1'b1, 8'h12, 8'h80, 0, cyc);
    chk("ns_flags", {o_nack_slave, o_nack_addr, o_nack_data}, 3'b100);
    chk("ns_len", cyc, 440);
    chk("ns_nbytes", rx_q.size(), 1);
    chk("ns_stops", stops, 1);

    // Next command clears the flag; a write pulse mid-transfer is ignored.
    present = 1'b1;
    do_cmd(1'b1, 8'h12, 8'h80, 500, cyc);
    chk("clr_flags", {o_nack_slave, o_nack_addr, o_nack_data}, 3'b000);
    chk("ign_b0", rx_q[0], 8'h84);
    chk("ign_b2", rx_q[2], 8'h80);
    chk("ign_len", cyc, 1160);
    repeat (50) @(negedge clk);
    chk("ign_idle", o_busy, 1'b0);

    // Data NACK with a 1000-cycle stretch during the register byte.
    nack_at = 3; stretch_req = 1'b1;
    do_cmd(1'b1, 8'h12, 8'h80, 0, cyc);
    stretch_req = 1'b0;
    chk("nd_flags", {o_nack_slave, o_nack_addr, o_nack_data}, 3'b001);
    chk("st_len", (cyc > 2100 && cyc < 2200), 1'b1);
    chk("st_b1", rx_q[1], 8'h12);
    chk("st_b2", rx_q[2], 8'h80);
    chk("nd_stops", stops, 1);

    // Register-address NACK aborts a read: no valid pulse, data held.
    nack_at = 2;
    v0 = vcnt;
    do_cmd(1'b0, 8'h0A, 8'h00, 0, cyc);
    chk("na_flags", {o_nack_slave, o_nack_addr, o_nack_data}, 3'b010);
    chk("na_valid_cnt", vcnt - v0, 0);
    chk("na_rdata", o_rdata, 8'hA3);
    chk("na_nbytes", rx_q.size(), 2);
    nack_at = 0;

    present = 1'b0;
    v0 = vcnt;
    do_cmd(1'b0, 8'h0A, 8'h00, 0, cyc);
    chk("nsr_flags", {o_nack_slave, o_nack_addr, o_nack_data}, 3'b100);
    chk("nsr_valid_cnt", vcnt - v0, 0);
    present = 1'b1;

    // Reset in the middle of the address byte.
    @(negedge clk);
    i_wr = 1'b1; i_reg_addr = 8'h12; i_wdata = 8'h80; i_slave_addr = 7'h42;
    @(negedge clk);
    i_wr = 1'b0;
    repeat (200) @(negedge clk);
    chk("mid_busy", o_busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_busy", o_busy, 1'b0);
    chk("mrst_bus", {scl, sda}, 2'b11);
    chk("mrst_rdata", o_rdata, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    do_cmd(1'b1, 8'h01, 8'h5A, 0, cyc);
    chk("rec_b1", rx_q[1], 8'h01);
    chk("rec_b2", rx_q[2], 8'h5A);
    chk("rec_len", cyc, 1160);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_master_core.md
Name: i2c_master_core

Overview:
Single-master I2C controller for 8-bit register access on 7-bit-addressed slaves (e.g. camera sensor configuration). A one-cycle command pulse starts a register write (START, addr+W, reg, data, STOP) or a register read (START, addr+W, reg, repeated START, addr+R, data, master NACK, STOP). The block drives open-drain SCL/SDA and reports busy, read-data-valid and per-frame NACK status.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
I2C_FREQ, 100_000, SCL frequency in Hz; quarter period Q = CLK_FREQ/(4*I2C_FREQ) cycles (250 at defaults)

Ports:
i_clk  in  1  system clock, all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_wr  in  1  write command pulse, sampled only when idle
i_rd  in  1  read command pulse, sampled only when idle
i_slave_addr  in  7  slave device address
i_reg_addr  in  8  register address
i_wdata  in  8  write data
o_rdata  out  8  read data, held until next read completes
o_busy  out  1  high while a transaction is in progress
o_rdata_valid  out  1  one-cycle pulse when o_rdata updated
o_nack_slave  out  1  NACK on an address frame (W or R)
o_nack_addr  out  1  NACK on register address frame
o_nack_data  out  1  NACK on write data frame
SCL  inout  1  open-drain clock: drive 0 or Z only
SDA  inout  1  open-drain data: drive 0 or Z only

Behaviour:
- Reset: SCL/SDA released (Z), o_busy=0, o_rdata=0, o_rdata_valid=0, all NACK flags 0, FSM IDLE, divider cleared. Reset mid-transfer aborts immediately and releases bus (no STOP).
- IDLE: if i_wr=1 accept write; else if i_rd=1 accept read (i_wr wins when both). Latch addr/reg/data on accept; o_busy=1 from next cycle until after STOP bus-free time; clear all NACK flags on accept. Commands while busy ignored.
- States: IDLE, START, SEND_BYTE, GET_ACK, RESTART, READ_BYTE, SEND_NACK, STOP.
- START: SDA low, wait 2Q; SCL low, wait Q.
- Bit slot (4Q): Q0 SCL low; SDA updated at start of Q1; Q2-Q3 SCL released; SDA sampled at end of Q2. MSB first.
- Clock stretching: after releasing SCL, quarter counter holds until SCL reads 1.
- ACK slot: SDA released; sampled 0=ACK, 1=NACK.
- Write: bytes {addr,0}, reg, wdata, each followed by ACK slot, then STOP.
- Read: {addr,0}, reg, RESTART (SCL low: release SDA Q, release SCL 2Q, SDA low 2Q, SCL low Q), {addr,1}, READ_BYTE (SDA released 8 bits), SEND_NACK (SDA released during 9th bit), STOP; o_rdata loaded and o_rdata_valid pulsed one cycle in the cycle STOP begins.
- NACK: set corresponding flag (o_nack_slave for either address frame), skip remaining frames, go to STOP. Flags hold until next accepted command. No o_rdata_valid on aborted read.
- STOP: SCL low with SDA low Q; release SCL, wait 2Q; release SDA, wait 2Q bus-free; then o_busy=0, IDLE.
- Write total ~= START + 27 bit slots + STOP.

Test Plan:
- Reset then idle: SCL=SDA=1 (pull-ups), o_busy=0, flags 0, o_rdata=0.
- Write 0x80 to reg 0x12, slave 0x42, ACKing slave model -> model decodes bytes 0x84,0x12,0x80, START/STOP legal, no NACK flags, o_busy low after STOP.
- Read reg 0x0A, slave 0x42, model returns 0x5C -> bytes 0x84,0x0A, repeated START, 0x85; o_rdata=0x5C with one-cycle o_rdata_valid; master NACKs last byte.
- No slave at 0x42 -> o_nack_slave=1 after first byte, STOP issued, others 0; next command clears flag.
- Slave NACKs data 0x80 -> o_nack_data=1 only; slave stretches SCL 1000 cycles -> transfer pauses then completes correctly.
- i_wr pulse while busy ignored; i_rst asserted mid-byte -> bus released next cycle, o_busy=0.
